// File: rtl/key_repeat_generator.sv
// key_repeat_generator
// Multi-channel auto-repeat generator for active-low push-buttons. Each channel
// synchronises its raw key, debounces it, and runs a small FSM that emits a
// one-cycle strobe on press, after an initial pause, at a slow repeat rate, and
// after ACCEL_COUNT slow repeats at a faster rate. A global enable forces every
// FSM back to Idle without disturbing the debouncers.

module key_repeat_generator #(
    parameter int CLOCK_PERIOD_NS = 20,
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_NS     = 10_000_000,
    parameter int PAUSE_NS        = 250_000_000,
    parameter int REPEAT_NS       = 150_000_000,
    parameter int FAST_NS         = 50_000_000,
    parameter int ACCEL_COUNT     = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                iEnable,
    input  logic [NUM_KEYS-1:0] iKeys,
    output logic [NUM_KEYS-1:0] oPulse,
    output logic [NUM_KEYS-1:0] oHeld,
    output logic [NUM_KEYS-1:0] oFast
);

    // Interval lengths in clock cycles.
    localparam int D = DEBOUNCE_NS / CLOCK_PERIOD_NS;
    localparam int P = PAUSE_NS / CLOCK_PERIOD_NS;
    localparam int R = REPEAT_NS / CLOCK_PERIOD_NS;
    localparam int F = FAST_NS / CLOCK_PERIOD_NS;

    // The interval counter must reach the largest terminal value of the three.
    localparam int MAX_PR  = (P > R) ? P : R;
    localparam int MAX_PRF = (MAX_PR > F) ? MAX_PR : F;
    localparam int CNT_W   = (MAX_PRF > 1) ? $clog2(MAX_PRF) : 1;
    localparam int DB_W    = (D > 1) ? $clog2(D) : 1;
    localparam int REP_W   = (ACCEL_COUNT > 0) ? $clog2(ACCEL_COUNT + 1) : 1;

    localparam logic [CNT_W-1:0] P_LAST  = CNT_W'(P - 1);
    localparam logic [CNT_W-1:0] R_LAST  = CNT_W'(R - 1);
    localparam logic [CNT_W-1:0] F_LAST  = CNT_W'(F - 1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(D - 1);
    localparam logic [REP_W-1:0] ACCEL_N = REP_W'(ACCEL_COUNT);
    localparam bit               FAST_EN = (ACCEL_COUNT != 0);
    localparam bit               ACCEL_1 = (ACCEL_COUNT == 1);

    // Parameter sanity: refuse to elaborate with intervals the FSM cannot honour.
    if (NUM_KEYS < 1) begin : g_bad_keys
        $error("key_repeat_generator: NUM_KEYS must be at least 1");
    end
    if (D < 1) begin : g_bad_debounce
        $error("key_repeat_generator: debounce interval must be at least 1 cycle");
    end
    if (P < 2) begin : g_bad_pause
        $error("key_repeat_generator: pause interval must be at least 2 cycles");
    end
    if (R < 2) begin : g_bad_repeat
        $error("key_repeat_generator: repeat interval must be at least 2 cycles");
    end
    if (F < 2) begin : g_bad_fast
        $error("key_repeat_generator: fast interval must be at least 2 cycles");
    end
    if (ACCEL_COUNT < 0) begin : g_bad_accel
        $error("key_repeat_generator: ACCEL_COUNT must not be negative");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PAUSE  = 2'd1,
        REPEAT = 2'd2,
        FAST   = 2'd3
    } state_t;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        // Synchroniser stages (1 = released, matching the idle button level).
        logic             sync_p0;
        logic             sync_p1;
        // Debounced raw level (1 = released) and its stability counter.
        logic             level;
        logic [DB_W-1:0]  db_cnt;
        logic             held;
        // Repeat FSM state.
        state_t           state;
        state_t           state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic [REP_W-1:0] rep;
        logic [REP_W-1:0] rep_nxt;
        logic             pulse;
        logic             pulse_nxt;

        // Two-flop synchroniser for the asynchronous raw key.
        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                sync_p0 <= 1'b1;
                sync_p1 <= 1'b1;
            end else begin
                sync_p0 <= iKeys[k];
                sync_p1 <= sync_p0;
            end
        end

        // Debouncer: accept a new level only after it differs for D edges in a row.
        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                level  <= 1'b1;
                db_cnt <= '0;
            end else if (sync_p1 == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                level  <= sync_p1;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end

        assign held = ~level;

        // FSM state, interval counter, repeat count and registered strobe.
        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                state <= IDLE;
                cnt   <= '0;
                rep   <= '0;
                pulse <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                rep   <= rep_nxt;
                pulse <= pulse_nxt;
            end
        end

        // Next-state logic; a release or disable overrides any terminal count.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            rep_nxt   = rep;
            pulse_nxt = 1'b0;
            if (!iEnable || !held) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                rep_nxt   = '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state_nxt = PAUSE;
                        pulse_nxt = 1'b1;
                        cnt_nxt   = '0;
                        rep_nxt   = '0;
                    end
                    PAUSE: begin
                        if (cnt == P_LAST) begin
                            pulse_nxt = 1'b1;
                            cnt_nxt   = '0;
                            rep_nxt   = REP_W'(1);
                            state_nxt = ACCEL_1 ? FAST : REPEAT;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (cnt == R_LAST) begin
                            pulse_nxt = 1'b1;
                            cnt_nxt   = '0;
                            rep_nxt   = rep + 1'b1;
                            if (FAST_EN && ((rep + 1'b1) == ACCEL_N)) begin
                                state_nxt = FAST;
                            end
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                    FAST: begin
                        if (cnt == F_LAST) begin
                            pulse_nxt = 1'b1;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        rep_nxt   = '0;
                    end
                endcase
            end
        end

        assign oPulse[k] = pulse;
        assign oHeld[k]  = held;
        assign oFast[k]  = (state == FAST);
    end

endmodule

// File: tb/tb_key_repeat_generator.sv
// Testbench for key_repeat_generator: directed scenarios plus randomized key and
// enable activity, compared every cycle against a timestamp-based reference model.

module tb_key_repeat_generator;

    localparam int NK = 3;
    localparam int D  = 3;
    localparam int P  = 10;
    localparam int R  = 4;
    localparam int F  = 2;
    localparam int A  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [NK-1:0] keys = '1;
    logic [NK-1:0] pulse;
    logic [NK-1:0] held;
    logic [NK-1:0] fast;

    key_repeat_generator #(
        .CLOCK_PERIOD_NS(1),
        .NUM_KEYS(NK),
        .DEBOUNCE_NS(3),
        .PAUSE_NS(10),
        .REPEAT_NS(4),
        .FAST_NS(2),
        .ACCEL_COUNT(A)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .iEnable(en),
        .iKeys(keys),
        .oPulse(pulse),
        .oHeld(held),
        .oFast(fast)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Single comparison point: counts and reports.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Raw level pipeline, debounced level with a run length of consecutive
    // disagreeing samples, and per-key press sessions identified by start edge.
    bit            m_s1  [NK];
    bit            m_s2  [NK];
    bit            m_lvl [NK];
    int            m_run [NK];
    bit            m_act [NK];
    int            m_t0  [NK];
    int            cyc;
    logic [NK-1:0] e_pulse;
    logic [NK-1:0] e_held;
    logic [NK-1:0] e_fast;

    // Strobe due k edges after the press strobe?
    function automatic bit is_strobe(int k);
        int j;
        if (k < P) return (k == 0);
        j = k - P;
        if (A == 0 || j <= (A - 1) * R) return (j % R) == 0;
        return ((j - (A - 1) * R) % F) == 0;
    endfunction

    // In fast mode k edges after the press strobe?
    function automatic bit is_fast(int k);
        return (A != 0) && (k >= P + (A - 1) * R);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            m_s1[k]  = 1'b1;
            m_s2[k]  = 1'b1;
            m_lvl[k] = 1'b1;
            m_run[k] = 0;
            m_act[k] = 1'b0;
            m_t0[k]  = 0;
        end
        e_pulse = '0;
        e_held  = '0;
        e_fast  = '0;
    endtask

    task automatic model_step();
        bit h;
        cyc++;
        for (int k = 0; k < NK; k++) begin
            h = !m_lvl[k];
            e_pulse[k] = 1'b0;
            if (m_act[k]) begin
                if (!en || !h) m_act[k] = 1'b0;
                else e_pulse[k] = is_strobe(cyc - m_t0[k]);
            end else if (en && h) begin
                m_act[k]   = 1'b1;
                m_t0[k]    = cyc;
                e_pulse[k] = 1'b1;
            end
            e_fast[k] = m_act[k] && is_fast(cyc - m_t0[k]);
            if (m_s2[k] != m_lvl[k]) begin
                m_run[k]++;
                if (m_run[k] == D) begin
                    m_lvl[k] = m_s2[k];
                    m_run[k] = 0;
                end
            end else begin
                m_run[k] = 0;
            end
            m_s2[k]   = m_s1[k];
            m_s1[k]   = keys[k];
            e_held[k] = !m_lvl[k];
        end
    endtask

    // ---------------- scenario bookkeeping ----------------
    int e;
    int ev0[$];
    int ev1[$];
    int ev2[$];
    int h0, h1, f0;

    task automatic scn_clear();
        e = 0;
        ev0.delete();
        ev1.delete();
        ev2.delete();
        h0 = 0;
        h1 = 0;
        f0 = 0;
    endtask

    function automatic int qat(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    // One clock: model advances on the edge, DUT compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        e++;
        chk($sformatf("pulse@%0d", cyc), 32'(pulse), 32'(e_pulse));
        chk($sformatf("held@%0d", cyc), 32'(held), 32'(e_held));
        chk($sformatf("fast@%0d", cyc), 32'(fast), 32'(e_fast));
        if (pulse[0]) ev0.push_back(e);
        if (pulse[1]) ev1.push_back(e);
        if (pulse[2]) ev2.push_back(e);
        if (held[0] && h0 == 0) h0 = e;
        if (held[1] && h1 == 0) h1 = e;
        if (fast[0] && f0 == 0) f0 = e;
    endtask

    int s1_exp[7] = '{6, 16, 20, 24, 26, 28, 30};
    int dur[NK];

    initial begin
        cyc = 0;
        model_reset();
        #12;
        chk("rst_pulse", 32'(pulse), 32'd0);
        chk("rst_held", 32'(held), 32'd0);
        chk("rst_fast", 32'(fast), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        en  = 1'b1;
        repeat (3) tick();

        // Scenario 1: hold key0 for 40 cycles.
        scn_clear();
        keys[0] = 1'b0;
        repeat (40) tick();
        for (int i = 0; i < 7; i++) chk($sformatf("s1_strobe%0d", i), qat(ev0, i), s1_exp[i]);
        chk("s1_held_rise", h0, 5);
        chk("s1_fast_rise", f0, 24);
        chk("s1_key1_quiet", ev1.size(), 0);
        chk("s1_key2_quiet", ev2.size(), 0);
        keys = '1;
        repeat (12) tick();

        // Scenario 2: glitch on key1 shorter than the debounce time.
        scn_clear();
        keys[1] = 1'b0;
        tick();
        tick();
        keys[1] = 1'b1;
        repeat (15) tick();
        chk("s2_no_strobe", ev1.size(), 0);
        chk("s2_no_held", h1, 0);

        // Scenario 3: debounced release lands on the terminal-count edge.
        scn_clear();
        keys[0] = 1'b0;
        repeat (10) tick();
        keys[0] = 1'b1;
        repeat (25) tick();
        chk("s3_strobes", ev0.size(), 1);
        chk("s3_press", qat(ev0, 0), 6);
        chk("s3_fast", 32'(fast[0]), 32'd0);
        repeat (5) tick();

        // Scenario 4: staggered presses on key0 and key2.
        scn_clear();
        keys[0] = 1'b0;
        repeat (3) tick();
        keys[2] = 1'b0;
        repeat (20) tick();
        chk("s4_k0_a", qat(ev0, 0), 6);
        chk("s4_k0_b", qat(ev0, 1), 16);
        chk("s4_k2_a", qat(ev2, 0), 9);
        chk("s4_k2_b", qat(ev2, 1), 19);
        keys = '1;
        repeat (12) tick();

        // Scenario 5: enable dropped for edges 18..21 while key0 held.
        scn_clear();
        keys[0] = 1'b0;
        repeat (17) tick();
        en = 1'b0;
        repeat (4) tick();
        chk("s5_held_while_off", 32'(held[0]), 32'd1);
        en = 1'b1;
        repeat (25) tick();
        chk("s5_a", qat(ev0, 0), 6);
        chk("s5_b", qat(ev0, 1), 16);
        chk("s5_c", qat(ev0, 2), 22);
        chk("s5_d", qat(ev0, 3), 32);
        chk("s5_fast_before_rst", 32'(fast[0]), 32'd1);

        // Scenario 6: asynchronous reset in fast mode, key0 kept held.
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("s6_pulse0", 32'(pulse), 32'd0);
        chk("s6_held0", 32'(held), 32'd0);
        chk("s6_fast0", 32'(fast), 32'd0);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        scn_clear();
        repeat (12) tick();
        chk("s6_press", qat(ev0, 0), 6);
        chk("s6_strobes", ev0.size(), 1);
        keys = '1;
        repeat (12) tick();

        // Randomized key/enable activity.
        for (int k = 0; k < NK; k++) dur[k] = $urandom_range(1, 30);
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (dur[k] == 0) begin
                    keys[k] = ~keys[k];
                    dur[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                         : $urandom_range(4, 45);
                end else begin
                    dur[k]--;
                end
            end
            en = ($urandom_range(0, 19) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_repeat_generator.md
Name: key_repeat_generator

Overview:
- Multi-channel keyboard auto-repeat generator for active-low push-buttons, generalised to NUM_KEYS independent channels.
- Each channel has a 2-flop synchroniser, a debouncer and its own repeat FSM.
- Emits one-cycle strobes:
  - on press;
  - after an initial pause;
  - at a repeat rate;
  - after ACCEL_COUNT repeats, at a faster rate.
- Sits between the board buttons and menu/counter logic, with a global enable.

Parameters:
- CLOCK_PERIOD_NS, 20: clock period in ns.
- NUM_KEYS, 3: number of independent key channels (≥1).
- DEBOUNCE_NS, 10_000_000: stability time before a level change is accepted; D = DEBOUNCE_NS/CLOCK_PERIOD_NS, must be ≥1.
- PAUSE_NS, 250_000_000: delay from first strobe to first repeat; P = PAUSE_NS/CLOCK_PERIOD_NS.
- REPEAT_NS, 150_000_000: slow repeat interval; R = REPEAT_NS/CLOCK_PERIOD_NS.
- FAST_NS, 50_000_000: fast repeat interval; F = FAST_NS/CLOCK_PERIOD_NS.
- ACCEL_COUNT, 8: slow repeat strobes before switching to fast; 0 disables fast mode.
- P, R and F must each be ≥2; elaboration fails otherwise.

Ports:
- Clock, input, 1: single system clock, rising edge.
- Reset, input, 1: asynchronous, active-high reset.
- iEnable, input, 1: 1 = strobes allowed; 0 = all FSMs forced Idle.
- iKeys, input, NUM_KEYS: raw buttons, active-low (0 = pressed), asynchronous to Clock.
- oPulse, output, NUM_KEYS: one-cycle active-high strobe per key event.
- oHeld, output, NUM_KEYS: debounced pressed level per key.
- oFast, output, NUM_KEYS: 1 while the channel is in state Fast.

Behaviour:
- Reset (asynchronous):
  - sync flops = 1 (released); debounced level = released.
  - FSM = Idle; all counters = 0.
  - oPulse = 0, oHeld = 0, oFast = 0.
- Synchroniser: raw key sampled through two flops, giving s2.
- Debouncer, per channel:
  - On each edge where s2 ≠ debounced level, cnt increments.
  - When cnt == D-1 and s2 still differs, the level takes s2 and cnt goes to 0.
  - Any edge where s2 == level clears cnt.
  - oHeld = registered debounced pressed level.
- FSM, per channel: states Idle, Pause, Repeat, Fast. Counter width = $clog2(max(P,R,F)); repeat-count width = $clog2(ACCEL_COUNT+1).
  - Idle:
    - On an edge where held=1 and iEnable=1: go to Pause, oPulse<=1, counter<=0, repcnt<=0.
  - Pause:
    - counter==P-1: oPulse<=1, counter<=0, repcnt<=1. Go to Fast if ACCEL_COUNT==1, else Repeat.
    - otherwise: counter+1.
  - Repeat:
    - counter==R-1: oPulse<=1, counter<=0, repcnt+1. Go to Fast when repcnt+1 == ACCEL_COUNT and ACCEL_COUNT≠0.
    - otherwise: counter+1.
  - Fast:
    - counter==F-1: oPulse<=1, counter<=0.
    - otherwise: counter+1.
  - oPulse is 0 on every edge that does not set it, so it is exactly one cycle wide.
- Strobe spacing:
  - Press strobe at T, first repeat at T+P.
  - Slow repeats every R until ACCEL_COUNT slow repeats (including the one at T+P) have been emitted.
  - Then every F.
- Latency:
  - Edge 1 is the first edge sampling the new raw level.
  - The debounced level changes after edge 2+D.
  - The press strobe is high in the cycle after edge 3+D.
- Release (held=0) in any non-Idle state:
  - Next edge: Idle, counter 0, oFast 0, no strobe.
  - If release coincides with a terminal count, release wins and there is no strobe.
- iEnable=0:
  - Next edge: all FSMs Idle, no strobes.
  - Debouncers and oHeld keep running.
  - Re-enabling while a key is held counts as a new press: strobe on the next edge, pause restarts.
- Channels are fully independent; simultaneous presses produce simultaneous strobes.
- Reset asserted mid-operation: all outputs 0 immediately, with no glitch strobe on deassert.

Test Plan:
Bench parameters: CLOCK_PERIOD_NS=1, NUM_KEYS=3, DEBOUNCE_NS=3, PAUSE_NS=10, REPEAT_NS=4, FAST_NS=2, ACCEL_COUNT=3.
1. Hold key0 low from edge 1 for 40 cycles:
   - oHeld[0] rises after edge 5.
   - oPulse[0] high after edges 6, 16, 20, 24, 26, 28, 30, …
   - oFast[0] rises after edge 24.
   - Keys 1 and 2 stay silent.
2. Raw key1 low for 2 cycles, then high (glitch shorter than D) → oHeld[1] and oPulse[1] stay 0 throughout.
3. Release key0 so that the debounced release lands on the edge scheduled for the strobe at 16 → no strobe at 16 or later; state Idle; oFast 0.
4. Press key0 at edge 1 and key2 at edge 4 → key0 strobes at 6, 16, …; key2 strobes at 9, 19, …; both independent and overlapping correctly.
5. Hold key0; drop iEnable for edges 18–21, then restore:
   - no strobes while disabled; oHeld[0] stays 1;
   - strobe on the edge after re-enable, next strobe 10 cycles later.
6. Assert Reset asynchronously mid-Fast, release it, keep key0 held → outputs 0 at once; new press strobe after edge 6 counted from the reset release.
